input_vc_buffer: RTL and testbench

- Input-port flit storage feeding router_top. One instance per router input port; holds NUM_VC independent FIFOs.
- Presents each VC's packet route to the allocators as a one-hot dst_port request, one vector per VC.
- Responds to the read side: when router_top issues vc_read_valid/vc_index, it pops the head flit of that VC.
- Returns one credit upstream per popped flit.

---
 rtl/router_pkg.sv | 31 +++
 rtl/vc_fifo.sv | 47 ++++
 rtl/input_vc_buffer.sv | 160 ++++++++++++++++
 tb/tb_input_vc_buffer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared flit encoding and route helpers for the router datapath.
// Imported by input_vc_buffer and vc_fifo.
package router_pkg;

  typedef enum logic [1:0] {
    FLIT_BODY     = 2'b00,
    FLIT_HEAD     = 2'b01,
    FLIT_TAIL     = 2'b10,
    FLIT_HEADTAIL = 2'b11
  } flit_type_e;

  typedef enum logic {
    VC_IDLE,
    VC_ACTIVE
  } vc_state_e;

  localparam int FLIT_TYPE_LSB = 0;
  localparam int FLIT_DST_LSB  = 2;
  localparam int FLIT_DST_W    = 3;
  localparam int PORT_SPAN     = 1 << FLIT_DST_W;

  function automatic logic [PORT_SPAN-1:0] onehot_port(
    input logic [FLIT_DST_W-1:0] idx
  );
    logic [PORT_SPAN-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/vc_fifo.sv
// Single-VC flit FIFO: power-of-two depth, head exposed combinationally.
// Pointers wrap naturally; caller never pops when empty or overfills.
module vc_fifo
  import router_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [$clog2(DEPTH):0] count,
  output logic [WIDTH-1:0]       head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + 1'b1;
      if (rd_en) rptr_q <= rptr_q + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign count = count_q;
  assign head  = mem_q[rptr_q];

endmodule

// File: rtl/input_vc_buffer.sv
// Per-input-port VC storage with route latch, pop path and credit return.
// INPUT_VC_BUF_ERR_EN adds sticky err_flags and per-VC drop counters.
module input_vc_buffer
  import router_pkg::*;
#(
  parameter int NUM_PORTS  = 5,
  parameter int NUM_VC     = 4,
  parameter int BUF_DEPTH  = 4,
  parameter int FLIT_WIDTH = 32
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_valid,
  input  logic [$clog2(NUM_VC)-1:0]           in_vc,
  input  logic [FLIT_WIDTH-1:0]               in_flit,
  input  logic                                vc_read_valid,
  input  logic [$clog2(NUM_VC)-1:0]           vc_index,
  output logic [NUM_VC-1:0][NUM_PORTS-1:0]    dst_port,
  output logic [NUM_VC-1:0]                   vc_occupied,
  output logic                                out_valid,
  output logic [FLIT_WIDTH-1:0]               out_flit,
  output logic                                credit_valid,
  output logic [$clog2(NUM_VC)-1:0]           credit_vc
`ifdef INPUT_VC_BUF_ERR_EN
  ,
  output logic [2:0]                          err_flags
`endif
);

  localparam int VW = $clog2(NUM_VC);
  localparam int CW = $clog2(BUF_DEPTH) + 1;

  logic [NUM_VC-1:0][CW-1:0]         cnt;
  logic [NUM_VC-1:0][FLIT_WIDTH-1:0] head;
  logic [NUM_VC-1:0]                 wr, rd;
`ifdef INPUT_VC_BUF_ERR_EN
  logic [NUM_VC-1:0]                 proto;
`endif

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    vc_state_e             state_q, state_d;
    logic [NUM_PORTS-1:0]  route_q, route_d;
    logic [NUM_PORTS-1:0]  dst_q, dst_d;
    logic [CW-1:0]         cnt_d;
    flit_type_e            ty;
    logic [FLIT_DST_W-1:0] idx;
    logic                  is_hd, is_tl;

    assign rd[v] = vc_read_valid && (vc_index == VW'(v))
                && (cnt[v] != '0);
    // A full VC still accepts a write when it is popped in the same cycle.
    assign wr[v] = in_valid && (in_vc == VW'(v))
                && ((cnt[v] < CW'(BUF_DEPTH)) || rd[v]);

    vc_fifo #(
      .DEPTH (BUF_DEPTH),
      .WIDTH (FLIT_WIDTH)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr[v]),
      .wr_data (in_flit),
      .rd_en   (rd[v]),
      .count   (cnt[v]),
      .head    (head[v])
    );

    assign ty    = flit_type_e'(head[v][FLIT_TYPE_LSB +: 2]);
    assign idx   = head[v][FLIT_DST_LSB +: FLIT_DST_W];
    assign is_hd = (ty == FLIT_HEAD) || (ty == FLIT_HEADTAIL);
    assign is_tl = (ty == FLIT_TAIL) || (ty == FLIT_HEADTAIL);

    always_comb begin
      state_d = state_q;
      route_d = route_q;
      if (state_q == VC_IDLE) begin
        if ((cnt[v] != '0) && is_hd) begin
          route_d = NUM_PORTS'(onehot_port(idx));
          state_d = (rd[v] && is_tl) ? VC_IDLE : VC_ACTIVE;
        end
      end else if (rd[v] && is_tl) begin
        state_d = VC_IDLE;
      end
      cnt_d = cnt[v] + CW'(wr[v]) - CW'(rd[v]);
      dst_d = ((state_d == VC_ACTIVE) && (cnt_d != '0))
            ? route_d : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q <= VC_IDLE;
        route_q <= '0;
        dst_q   <= '0;
      end else begin
        state_q <= state_d;
        route_q <= route_d;
        dst_q   <= dst_d;
      end
    end

`ifdef INPUT_VC_BUF_ERR_EN
    assign proto[v] = (state_q == VC_IDLE) && (cnt[v] != '0)
                   && (!is_hd || (idx >= NUM_PORTS));
`endif

    assign dst_port[v]    = dst_q;
    assign vc_occupied[v] = (cnt[v] != '0);
  end

  logic                  pop_any;
  logic                  out_valid_q, credit_valid_q;
  logic [FLIT_WIDTH-1:0] out_flit_q;
  logic [VW-1:0]         credit_vc_q;

  assign pop_any = |rd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q    <= 1'b0;
      credit_valid_q <= 1'b0;
      out_flit_q     <= '0;
      credit_vc_q    <= '0;
    end else begin
      out_valid_q    <= pop_any;
      credit_valid_q <= pop_any;
      if (pop_any) begin
        out_flit_q  <= head[vc_index];
        credit_vc_q <= vc_index;
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign out_flit     = out_flit_q;
  assign credit_valid = credit_valid_q;
  assign credit_vc    = credit_vc_q;

`ifdef INPUT_VC_BUF_ERR_EN
  logic       ovf_ev, udf_ev;
  logic [2:0] err_q;
  logic [7:0] drop_cnt_q [NUM_VC];

  assign ovf_ev = in_valid && !(|wr);
  assign udf_ev = vc_read_valid && !pop_any;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= '0;
      for (int i = 0; i < NUM_VC; i++) drop_cnt_q[i] <= '0;
    end else begin
      err_q <= err_q | {(|proto), udf_ev, ovf_ev};
      if (ovf_ev && (drop_cnt_q[in_vc] != 8'hFF))
        drop_cnt_q[in_vc] <= drop_cnt_q[in_vc] + 8'd1;
    end
  end

  assign err_flags = err_q;
`endif

endmodule

// File: tb/tb_input_vc_buffer.sv
// Self-checking bench for input_vc_buffer: vector table plus corner sequences.
// Popped flits are checked against a scoreboard fed by a per-VC FIFO model.
module tb_input_vc_buffer;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic [1:0]        in_vc;
  logic [31:0]       in_flit;
  logic              vc_read_valid;
  logic [1:0]        vc_index;
  logic [3:0][4:0]   dst_port;
  logic [3:0]        vc_occupied;
  logic              out_valid;
  logic [31:0]       out_flit;
  logic              credit_valid;
  logic [1:0]        credit_vc;
`ifdef INPUT_VC_BUF_ERR_EN
  logic [2:0]        err_flags;
`endif

  input_vc_buffer #(
    .NUM_PORTS  (5),
    .NUM_VC     (4),
    .BUF_DEPTH  (4),
    .FLIT_WIDTH (32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_vc         (in_vc),
    .in_flit       (in_flit),
    .vc_read_valid (vc_read_valid),
    .vc_index      (vc_index),
    .dst_port      (dst_port),
    .vc_occupied   (vc_occupied),
    .out_valid     (out_valid),
    .out_flit      (out_flit),
    .credit_valid  (credit_valid),
    .credit_vc     (credit_vc)
`ifdef INPUT_VC_BUF_ERR_EN
    ,
    .err_flags     (err_flags)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] flit;
    logic [1:0]  vc;
  } exp_t;

  typedef struct {
    logic        wv;
    logic [1:0]  wvc;
    logic [31:0] wf;
    logic        rv;
    logic [1:0]  rvc;
    logic [19:0] dst;
  } vec_t;

  exp_t        sb[$];
  vec_t        tbl[11];
  logic [31:0] mmem [4][4];
  int          mhd [4];
  int          mn  [4];
  int          n_tests;
  int          n_fail;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic wv, input logic [1:0] wvc,
                      input logic [31:0] wf, input logic rv,
                      input logic [1:0] rvc);
    logic       ep;
    logic [3:0] eo;
    exp_t       e;
    in_valid      = wv;
    in_vc         = wvc;
    in_flit       = wf;
    vc_read_valid = rv;
    vc_index      = rvc;
    ep = 1'b0;
    if (rv && mn[rvc] > 0) begin
      e.flit   = mmem[rvc][mhd[rvc]];
      e.vc     = rvc;
      mhd[rvc] = (mhd[rvc] + 1) % 4;
      mn[rvc]--;
      sb.push_back(e);
      ep = 1'b1;
    end
    if (wv && mn[wvc] < 4) begin
      mmem[wvc][(mhd[wvc] + mn[wvc]) % 4] = wf;
      mn[wvc]++;
    end
    @(posedge clk);
    #1;
    in_valid      = 1'b0;
    vc_read_valid = 1'b0;
    chk("out_valid", {31'd0, out_valid}, {31'd0, ep});
    chk("credit_valid", {31'd0, credit_valid}, {31'd0, ep});
    if (out_valid && sb.size() > 0) begin
      e = sb.pop_front();
      chk("out_flit", out_flit, e.flit);
      chk("credit_vc", {30'd0, credit_vc}, {30'd0, e.vc});
    end
    for (int i = 0; i < 4; i++) eo[i] = (mn[i] != 0);
    chk("vc_occupied", {28'd0, vc_occupied}, {28'd0, eo});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 32'd0, 1'b0, 2'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 4; i++) begin
      mhd[i] = 0;
      mn[i]  = 0;
    end
    tbl[0]  = '{1'b1, 2'd0, 32'hA000000F, 1'b0, 2'd0, 20'h00000};
    tbl[1]  = '{1'b0, 2'd0, 32'h00000000, 1'b0, 2'd0, 20'h00008};
    tbl[2]  = '{1'b0, 2'd0, 32'h00000000, 1'b1, 2'd0, 20'h00000};
    tbl[3]  = '{1'b0, 2'd0, 32'h00000000, 1'b0, 2'd0, 20'h00000};
    tbl[4]  = '{1'b1, 2'd2, 32'h11111101, 1'b0, 2'd0, 20'h00000};
    tbl[5]  = '{1'b1, 2'd2, 32'h22222200, 1'b0, 2'd0, 20'h00400};
    tbl[6]  = '{1'b1, 2'd2, 32'h33333302, 1'b0, 2'd0, 20'h00400};
    tbl[7]  = '{1'b0, 2'd0, 32'h00000000, 1'b1, 2'd2, 20'h00400};
    tbl[8]  = '{1'b0, 2'd0, 32'h00000000, 1'b1, 2'd2, 20'h00400};
    tbl[9]  = '{1'b0, 2'd0, 32'h00000000, 1'b1, 2'd2, 20'h00000};
    tbl[10] = '{1'b0, 2'd0, 32'h00000000, 1'b0, 2'd0, 20'h00000};

    reset         = 1'b0;
    in_valid      = 1'b0;
    in_vc         = '0;
    in_flit       = '0;
    vc_read_valid = 1'b0;
    vc_index      = '0;
    repeat (2) @(negedge clk);
    chk("rst dst_port", {12'd0, dst_port}, 32'd0);
    chk("rst vc_occupied", {28'd0, vc_occupied}, 32'd0);
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst credit_valid", {31'd0, credit_valid}, 32'd0);
    chk("rst out_flit", out_flit, 32'd0);
`ifdef INPUT_VC_BUF_ERR_EN
    chk("rst err_flags", {29'd0, err_flags}, 32'd0);
`endif
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].wv, tbl[i].wvc, tbl[i].wf, tbl[i].rv, tbl[i].rvc);
      chk($sformatf("vec%0d dst_port", i), {12'd0, dst_port},
          {12'd0, tbl[i].dst});
    end

    step(1'b1, 2'd1, 32'h44444405, 1'b0, 2'd0);
    step(1'b1, 2'd1, 32'h55555500, 1'b0, 2'd0);
    step(1'b1, 2'd1, 32'h66666600, 1'b0, 2'd0);
    step(1'b1, 2'd1, 32'h77777700, 1'b0, 2'd0);
    step(1'b1, 2'd1, 32'h88888800, 1'b0, 2'd0);
    chk("ovf dst_port", {12'd0, dst_port}, 32'h00040);
`ifdef INPUT_VC_BUF_ERR_EN
    chk("ovf flag", {31'd0, err_flags[0]}, 32'd1);
`endif
    for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 32'd0, 1'b1, 2'd1);
    chk("drained dst_port", {12'd0, dst_port}, 32'd0);
    step(1'b1, 2'd1, 32'h99999902, 1'b0, 2'd0);
    chk("wrap dst_port", {12'd0, dst_port}, 32'h00040);
    step(1'b0, 2'd0, 32'd0, 1'b1, 2'd1);
    chk("tail dst_port", {12'd0, dst_port}, 32'd0);

    step(1'b0, 2'd0, 32'd0, 1'b1, 2'd3);
`ifdef INPUT_VC_BUF_ERR_EN
    chk("udf flag", {31'd0, err_flags[1]}, 32'd1);
`endif

    step(1'b1, 2'd3, 32'hBBBBBB0F, 1'b1, 2'd3);
    step(1'b0, 2'd0, 32'd0, 1'b1, 2'd3);

    step(1'b1, 2'd0, 32'hCCCCCC00, 1'b0, 2'd0);
    idle(3);
    chk("proto dst_port", {12'd0, dst_port}, 32'd0);
`ifdef INPUT_VC_BUF_ERR_EN
    chk("proto flag", {31'd0, err_flags[2]}, 32'd1);
`endif
    step(1'b0, 2'd0, 32'd0, 1'b1, 2'd0);

    step(1'b1, 2'd1, 32'hDDDDDD09, 1'b0, 2'd0);
    step(1'b1, 2'd1, 32'hEEEEEE00, 1'b0, 2'd0);
    idle(1);
    chk("pre-rst dst_port", {12'd0, dst_port}, 32'h00080);
    #2;
    reset = 1'b0;
    #1;
    chk("async dst_port", {12'd0, dst_port}, 32'd0);
    chk("async vc_occupied", {28'd0, vc_occupied}, 32'd0);
    chk("async out_valid", {31'd0, out_valid}, 32'd0);
    chk("async credit_valid", {31'd0, credit_valid}, 32'd0);
    chk("async out_flit", out_flit, 32'd0);
    chk("async credit_vc", {30'd0, credit_vc}, 32'd0);
`ifdef INPUT_VC_BUF_ERR_EN
    chk("async err_flags", {29'd0, err_flags}, 32'd0);
`endif
    for (int i = 0; i < 4; i++) begin
      mhd[i] = 0;
      mn[i]  = 0;
    end
    #1;
    reset = 1'b1;

    step(1'b1, 2'd1, 32'hFFFFFF11, 1'b0, 2'd0);
    idle(1);
    chk("post-rst dst_port", {12'd0, dst_port}, 32'h00200);

    step(1'b1, 2'd2, 32'h12345615, 1'b0, 2'd0);
    idle(1);
    chk("bad dst dst_port", {12'd0, dst_port}, 32'h00200);
`ifdef INPUT_VC_BUF_ERR_EN
    chk("bad dst flag", {31'd0, err_flags[2]}, 32'd1);
`endif

    chk("scoreboard empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
